// File: rtl/mem_bridge_pkg.sv
// Shared types and default constants for the mem_bridge core-to-host bridge.
// Address window helpers used by the optional MEM_BRIDGE_ERR_EN range check.
package mem_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int unsigned DEF_LATENCY  = 2;
  localparam logic [63:0] DEF_MEM_BASE = 64'h8000_0000;
  localparam logic [63:0] DEF_MEM_SIZE = 64'h0800_0000;

  function automatic logic [63:0] align8(input logic [63:0] a);
    return {a[63:3], 3'b000};
  endfunction

  // Subtract before comparing so base+size never overflows.
  function automatic logic in_window(
    input logic [63:0] a,
    input logic [63:0] base,
    input logic [63:0] size
  );
    return (a >= base) && ((a - base) < size);
  endfunction

endpackage

// File: rtl/mem_bridge.sv
// Single-outstanding load/store bridge from core to host memory strobes.
// Define MEM_BRIDGE_ERR_EN to fault accesses outside [MEM_BASE, MEM_BASE+MEM_SIZE).
module mem_bridge
  import mem_bridge_pkg::*;
#(
  parameter int unsigned LATENCY  = DEF_LATENCY,
  parameter logic [63:0] MEM_BASE = DEF_MEM_BASE,
  parameter logic [63:0] MEM_SIZE = DEF_MEM_SIZE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [63:0] req_addr,
  input  logic        req_wen,
  input  logic [63:0] req_wdata,
  input  logic [7:0]  req_wmask,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  output logic [63:0] host_addr,
  output logic        host_ren,
  output logic        host_wen,
  output logic [63:0] host_wdata,
  output logic [7:0]  host_wmask,
  input  logic [63:0] host_rdata
);

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [63:0] addr_q;
  logic        wen_q;
  logic [63:0] wdata_q;
  logic [7:0]  wmask_q;
  logic        err_q;
  logic        resp_valid_q;
  logic [63:0] resp_rdata_q;
  logic        resp_err_q;
  logic [63:0] host_addr_q;
  logic        host_ren_q;
  logic        host_wen_q;
  logic [63:0] host_wdata_q;
  logic [7:0]  host_wmask_q;

  logic in_win_w;
  logic oor_w;
  logic acc_fire_w;
  logic wait_fire_w;

  assign in_win_w = in_window(req_addr, MEM_BASE, MEM_SIZE);

`ifdef MEM_BRIDGE_ERR_EN
  assign oor_w = !in_win_w;
`else
  logic unused_in_win;
  assign unused_in_win = in_win_w;
  assign oor_w = 1'b0;
`endif

  // Strobe fires on the cycle the counter reaches zero, so it is
  // registered one edge early: at accept when LATENCY is 1, else at cnt 1.
  assign acc_fire_w  = (CNT_INIT == 4'd0) && !oor_w;
  assign wait_fire_w = (cnt_q == 4'd1) && !err_q;

  // Request/response FSM with registered host strobes and response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      addr_q       <= '0;
      wen_q        <= 1'b0;
      wdata_q      <= '0;
      wmask_q      <= '0;
      err_q        <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      host_addr_q  <= '0;
      host_ren_q   <= 1'b0;
      host_wen_q   <= 1'b0;
      host_wdata_q <= '0;
      host_wmask_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_valid) begin
            addr_q       <= align8(req_addr);
            wen_q        <= req_wen;
            wdata_q      <= req_wdata;
            wmask_q      <= req_wmask;
            err_q        <= oor_w;
            cnt_q        <= CNT_INIT;
            host_ren_q   <= acc_fire_w && !req_wen;
            host_wen_q   <= acc_fire_w && req_wen;
            host_addr_q  <= acc_fire_w ? align8(req_addr) : '0;
            host_wdata_q <= acc_fire_w ? req_wdata : '0;
            host_wmask_q <= acc_fire_w ? req_wmask : '0;
            state_q      <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_q == 4'd0) begin
            resp_rdata_q <= host_ren_q ? host_rdata : '0;
            resp_err_q   <= err_q;
            resp_valid_q <= 1'b1;
            host_ren_q   <= 1'b0;
            host_wen_q   <= 1'b0;
            host_addr_q  <= '0;
            host_wdata_q <= '0;
            host_wmask_q <= '0;
            state_q      <= RESP;
          end else begin
            cnt_q        <= cnt_q - 4'd1;
            host_ren_q   <= wait_fire_w && !wen_q;
            host_wen_q   <= wait_fire_w && wen_q;
            host_addr_q  <= wait_fire_w ? addr_q : '0;
            host_wdata_q <= wait_fire_w ? wdata_q : '0;
            host_wmask_q <= wait_fire_w ? wmask_q : '0;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready  = (state_q == IDLE) && !rst;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign host_addr  = host_addr_q;
  assign host_ren   = host_ren_q;
  assign host_wen   = host_wen_q;
  assign host_wdata = host_wdata_q;
  assign host_wmask = host_wmask_q;

endmodule

// File: doc/mem_bridge.md
MEM_BRIDGE -- requirements
Module: mem_bridge

Interface
REQ-001 SHALL have parameter LATENCY, default 2, meaning wait cycles between request accept and host strobe (legal 1..15).
REQ-002 SHALL have parameter MEM_BASE, default 64'h8000_0000, meaning the lowest valid physical address.
REQ-003 SHALL have parameter MEM_SIZE, default 64'h0800_0000, meaning the valid window size in bytes.
REQ-004 SHALL have ports:
  clk  in  1  sole clock, rising edge;
  rst  in  1  reset, synchronous, active-high;
  req_valid  in  1  core request valid;
  req_ready  out  1  bridge can accept;
  req_addr  in  64  byte address;
  req_wen  in  1  1=store, 0=load;
  req_wdata  in  64  store data;
  req_wmask  in  8  store byte enables;
  resp_valid  out  1  response valid;
  resp_ready  in  1  core takes response;
  resp_rdata  out  64  load data;
  resp_err  out  1  access fault;
  host_addr  out  64  8-byte-aligned host address;
  host_ren  out  1  host read strobe;
  host_wen  out  1  host write strobe;
  host_wdata  out  64  host write data;
  host_wmask  out  8  host byte enables;
  host_rdata  in  64  host read data, valid in the cycle host_ren=1.

Function
REQ-005 SHALL implement FSM states IDLE, WAIT, RESP; req_ready=1 only in IDLE.
REQ-006 SHALL accept when req_valid&&req_ready at a rising edge: latch addr/wen/wdata/wmask, load counter with LATENCY-1, go WAIT.
REQ-007 SHALL in WAIT decrement counter each cycle; when counter==0, assert exactly one of host_ren/host_wen for that single cycle, then go RESP at the next edge.
REQ-008 SHALL drive host_addr = latched addr with bits [2:0] cleared, host_wdata/host_wmask = latched values; host_* data outputs hold 0 whenever no strobe.
REQ-009 SHALL capture host_rdata into resp_rdata at the strobe edge for loads; resp_rdata=0 for stores.
REQ-010 SHALL assert resp_valid in RESP, holding resp_rdata/resp_err stable until resp_valid&&resp_ready, then return to IDLE.
REQ-011 SHALL give load/store response at cycle accept+LATENCY+1 when resp_ready is held high; minimum request spacing LATENCY+2 cycles.
REQ-012 SHALL ignore req_* while not IDLE; no queuing, no second outstanding request.
REQ-013 SHALL treat req_wen=1 with req_wmask=0 as a normal store: host_wen pulses with wmask 0.

Reset
REQ-014 SHALL on rst=1 at an edge force IDLE, counter 0, resp_valid=0, resp_rdata=0, resp_err=0, host_ren=host_wen=0, all host data outputs 0.
REQ-015 SHALL on reset during WAIT or RESP drop the transaction: no host strobe after the reset edge, no response.
REQ-016 SHALL drive req_ready=0 while rst=1.

Configuration
REQ-017 SHALL with MEM_BRIDGE_ERR_EN defined check latched addr against [MEM_BASE, MEM_BASE+MEM_SIZE); out of range: no host strobe, resp_err=1, resp_rdata=0, same latency.
REQ-018 SHALL without MEM_BRIDGE_ERR_EN tie resp_err to 0 and forward every address to the host.

Structure
REQ-019 SHALL place the state enum type and default MEM_BASE/MEM_SIZE/LATENCY constants in shared package mem_bridge_pkg.
REQ-020 SHALL be a single module; no sub-module.

Verification
REQ-021 Load, LATENCY=2, addr 0x8000_0010, host_rdata 0xDEAD_BEEF_0123_4567 -> host_ren one cycle at cycle 2 with host_addr 0x8000_0010; resp_valid cycle 3, rdata matches, err 0.
REQ-022 Store addr 0x8000_0013, wdata 0x11, wmask 0x08 -> single host_wen pulse, host_addr 0x8000_0010, wmask 0x08; resp_rdata 0.
REQ-023 Backpressure: resp_ready low 5 cycles -> resp_valid/rdata stable 5 cycles, req_ready 0 throughout; IDLE the cycle after handshake.
REQ-024 rst asserted mid-WAIT -> no host strobe, no resp_valid, all outputs 0 next cycle; subsequent load completes normally.
REQ-025 MEM_BRIDGE_ERR_EN defined, load addr 0x0000_1000 -> no host_ren, resp_err 1, rdata 0 at cycle LATENCY+1; undefined -> host_ren fires, err 0.
